// File: rtl/car_traffic_scheduler.sv
// -----------------------------------------------------------------------------
// car_traffic_scheduler
//
// Frame-synchronous traffic controller for the four car sprites. A private
// copy of the display's h/v timing produces a one-cycle frame tick at the
// start of vertical blanking. On each tick in PLAY the frog is tested against
// every car. A hit freezes traffic for HIT_FREEZE_FRAMES ticks before the cars
// return to their home positions. Otherwise the cars advance one step every
// FRAMES_PER_STEP ticks.
//
// Car positions are registered on the edge that ends the tick cycle. They
// therefore change only during blanking, never while a frame is drawn.
//
// Ports
//   i_Clk           pixel clock (same clock as the display)
//   i_Rst_L         asynchronous active-low reset
//   i_Enable        game running; low pauses traffic (ignored while frozen)
//   i_Level         speed multiplier minus one (0..3)
//   i_Frog_X/Y      frog top-left corner, sampled only on frame ticks
//   o_Car_1X..4X    car left-corner X, always within 0..H_VISIBLE_AREA-1
//   o_Car_1Y..4Y    car top-corner Y (fixed lanes)
//   o_Frame_Tick    one-cycle pulse at the start of vertical blanking
//   o_Collision     one-cycle pulse when a hit is registered
//   o_State         0=IDLE, 1=PLAY, 2=HIT, 3=RESTART
// -----------------------------------------------------------------------------
module car_traffic_scheduler #(
  parameter int TILE_SIZE         = 32,
  parameter int H_VISIBLE_AREA    = 640,
  parameter int V_VISIBLE_AREA    = 480,
  parameter int H_TOTAL           = 800,
  parameter int V_TOTAL           = 525,
  parameter int FRAMES_PER_STEP   = 1,
  parameter int HIT_FREEZE_FRAMES = 60
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  input  logic [1:0] i_Level,
  input  logic [9:0] i_Frog_X,
  input  logic [9:0] i_Frog_Y,
  output logic [9:0] o_Car_1X,
  output logic [9:0] o_Car_2X,
  output logic [9:0] o_Car_3X,
  output logic [9:0] o_Car_4X,
  output logic [8:0] o_Car_1Y,
  output logic [8:0] o_Car_2Y,
  output logic [8:0] o_Car_3Y,
  output logic [8:0] o_Car_4Y,
  output logic       o_Frame_Tick,
  output logic       o_Collision,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_HIT     = 2'd2,
    ST_RESTART = 2'd3
  } state_t;

  localparam int H_W   = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_W   = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int FZ_W  = (HIT_FREEZE_FRAMES > 1) ? $clog2(HIT_FREEZE_FRAMES) : 1;

  localparam logic [H_W-1:0]   H_LAST      = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST      = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_BLANK     = V_W'(V_VISIBLE_AREA);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [FZ_W-1:0]  FREEZE_LOAD = FZ_W'(HIT_FREEZE_FRAMES - 1);
  localparam logic [10:0]      X_WRAP      = 11'(H_VISIBLE_AREA);
  localparam logic signed [10:0] TILE_S    = 11'(TILE_SIZE);

  // Home positions; the Y lanes never change, so they are constants.
  localparam logic [9:0] HOME_X [4] = '{10'd0, 10'd608, 10'd160, 10'd448};
  localparam logic [8:0] HOME_Y [4] = '{9'd96, 9'd160, 9'd224, 9'd288};

  // ---------------------------------------------------------------------------
  // Frame timing: mirrors the display's h/v counters so that the tick lands
  // on the first blanking line of every frame.
  // ---------------------------------------------------------------------------
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           frame_tick_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= (h_cnt == '0) && (v_cnt == V_BLANK);
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Motion arithmetic. Stepping right wraps past the visible width back to
  // the left edge. Stepping left borrows the visible width when the step
  // would go below zero. X therefore always stays inside the visible area.
  // ---------------------------------------------------------------------------
  function automatic logic [9:0] step_x(input logic [9:0] x,
                                        input logic [4:0] step,
                                        input logic       right);
    logic [10:0] sum;
    sum = {1'b0, x} + {6'd0, step};
    if (right) begin
      return (sum >= X_WRAP) ? 10'(sum - X_WRAP) : sum[9:0];
    end
    return (x < {5'd0, step}) ? 10'({1'b0, x} + X_WRAP - {6'd0, step})
                              : x - {5'd0, step};
  endfunction

  state_t           state_q, state_d;
  logic [9:0]       car_x_q [4];
  logic [9:0]       car_x_d [4];
  logic [9:0]       moved_x [4];
  logic [DIV_W-1:0] div_q, div_d;
  logic [FZ_W-1:0]  freeze_q, freeze_d;
  logic             collision_q, collision_d;
  logic [3:0]       hit_vec;
  logic [2:0]       lvl_inc;

  // Candidate positions for a move and the per-car overlap test. Both use the
  // current (pre-update) positions. The FSM decides which result applies.
  always_comb begin
    logic [4:0]          step;
    logic signed [10:0]  dx;
    logic signed [10:0]  dy;
    lvl_inc = {1'b0, i_Level} + 3'd1;
    hit_vec = '0;
    for (int k = 0; k < 4; k++) begin
      // Car k+1 advances (k+1)*(level+1) px: at most 4*4 = 16.
      step       = 5'(k + 1) * {2'b00, lvl_inc};
      // Even indices (cars 1 and 3) travel right, odd ones travel left.
      moved_x[k] = step_x(car_x_q[k], step, (k % 2) == 0);
      dx         = $signed({1'b0, i_Frog_X}) - $signed({1'b0, car_x_q[k]});
      dy         = $signed({1'b0, i_Frog_Y}) - $signed({2'b00, HOME_Y[k]});
      hit_vec[k] = (dx < TILE_S) && (dx > -TILE_S) &&
                   (dy < TILE_S) && (dy > -TILE_S);
    end
  end

  // ---------------------------------------------------------------------------
  // Game FSM, next-state and datapath update.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a hold/default value first, so no
  // path through the case statement can leave one unassigned and infer a
  // latch.
  always_comb begin
    state_d     = state_q;
    car_x_d     = car_x_q;
    div_d       = div_q;
    freeze_d    = freeze_q;
    collision_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Entering PLAY only arms the game; the first move comes on a later tick.
        if (frame_tick_q && i_Enable) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (!i_Enable) begin
          state_d = ST_IDLE;
        end else if (frame_tick_q) begin
          // A hit outranks a move that falls on the same tick.
          if (|hit_vec) begin
            state_d     = ST_HIT;
            collision_d = 1'b1;
            freeze_d    = FREEZE_LOAD;
          end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            car_x_d = moved_x;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      ST_HIT: begin
        // Frozen: count ticks down and ignore i_Enable until the freeze ends.
        if (frame_tick_q) begin
          if (freeze_q == '0) begin
            state_d = ST_RESTART;
          end else begin
            freeze_d = freeze_q - 1'b1;
          end
        end
      end
      ST_RESTART: begin
        car_x_d = HOME_X;
        div_d   = '0;
        state_d = i_Enable ? ST_PLAY : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the position array is only four registers, and it must come out of
  // reset at the home positions, so it is reset like any other state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      car_x_q     <= HOME_X;
      div_q       <= '0;
      freeze_q    <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      car_x_q     <= car_x_d;
      div_q       <= div_d;
      freeze_q    <= freeze_d;
      collision_q <= collision_d;
    end
  end

  assign o_Car_1X     = car_x_q[0];
  assign o_Car_2X     = car_x_q[1];
  assign o_Car_3X     = car_x_q[2];
  assign o_Car_4X     = car_x_q[3];
  assign o_Car_1Y     = HOME_Y[0];
  assign o_Car_2Y     = HOME_Y[1];
  assign o_Car_3Y     = HOME_Y[2];
  assign o_Car_4Y     = HOME_Y[3];
  assign o_Frame_Tick = frame_tick_q;
  assign o_Collision  = collision_q;
  assign o_State      = state_q;

endmodule

// File: tb/tb_car_traffic_scheduler.sv
// -----------------------------------------------------------------------------
// tb_car_traffic_scheduler
//
// Self-checking bench. The frame timing is shrunk (10 x 5 clocks per frame)
// so that long motion sequences fit in a short run. The X wrap width stays
// 640. A behavioural model advances once per clock and predicts every
// output. Ticks come from edge-count arithmetic. Motion uses modular
// arithmetic, and overlap uses integer absolute differences. A compare
// process checks all outputs on every falling edge. Directed sequences pin
// the model with hand-computed literals. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_car_traffic_scheduler;

  localparam int HT       = 10;
  localparam int VT       = 5;
  localparam int VV       = 3;
  localparam int HV       = 640;
  localparam int TS       = 32;
  localparam int FPS      = 2;
  localparam int HFF      = 60;
  localparam int FRAME    = HT * VT;
  localparam int TICK_POS = VV * HT + 1;  // edges after reset release to first tick

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       enable   = 1'b0;
  logic [1:0] level    = 2'd0;
  logic [9:0] frog_x   = 10'd320;
  logic [9:0] frog_y   = 10'd448;

  logic [9:0] car_1x, car_2x, car_3x, car_4x;
  logic [8:0] car_1y, car_2y, car_3y, car_4y;
  logic       frame_tick, collision;
  logic [1:0] state;

  always #5 clk = ~clk;

  car_traffic_scheduler #(
    .TILE_SIZE(TS), .H_VISIBLE_AREA(HV), .V_VISIBLE_AREA(VV),
    .H_TOTAL(HT), .V_TOTAL(VT), .FRAMES_PER_STEP(FPS), .HIT_FREEZE_FRAMES(HFF)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(enable), .i_Level(level),
    .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
    .o_Car_1X(car_1x), .o_Car_2X(car_2x), .o_Car_3X(car_3x), .o_Car_4X(car_4x),
    .o_Car_1Y(car_1y), .o_Car_2Y(car_2y), .o_Car_3Y(car_3y), .o_Car_4Y(car_4y),
    .o_Frame_Tick(frame_tick), .o_Collision(collision), .o_State(state)
  );

  logic [9:0] dut_x [4];
  logic [8:0] dut_y [4];
  assign dut_x[0] = car_1x;  assign dut_x[1] = car_2x;
  assign dut_x[2] = car_3x;  assign dut_x[3] = car_4x;
  assign dut_y[0] = car_1y;  assign dut_y[1] = car_2y;
  assign dut_y[2] = car_3y;  assign dut_y[3] = car_4y;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int  home_x [4] = '{0, 608, 160, 448};
  int  home_y [4] = '{96, 160, 224, 288};
  int  m_state;            // 0 idle, 1 play, 2 hit, 3 restart
  int  m_x [4];
  int  m_frames;           // frames counted toward the next step
  int  m_freeze;           // remaining frozen ticks before restart
  bit  m_coll;
  int  m_n;                // rising edges since reset release
  int  tick_count = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_x      = home_x;
    m_frames = 0;
    m_freeze = 0;
    m_coll   = 1'b0;
    m_n      = 0;
  endtask

  task automatic model_step(input bit tick);
    int  fx, fy, step;
    bit  hit;
    fx     = frog_x;
    fy     = frog_y;
    m_coll = 1'b0;
    case (m_state)
      0: if (tick && enable) m_state = 1;
      1: begin
        if (!enable) begin
          m_state = 0;
        end else if (tick) begin
          hit = 1'b0;
          for (int k = 0; k < 4; k++)
            if (iabs(fx - m_x[k]) < TS && iabs(fy - home_y[k]) < TS) hit = 1'b1;
          if (hit) begin
            m_state  = 2;
            m_coll   = 1'b1;
            m_freeze = HFF - 1;
          end else begin
            m_frames++;
            if (m_frames == FPS) begin
              m_frames = 0;
              for (int k = 0; k < 4; k++) begin
                step = (k + 1) * (int'(level) + 1);
                if (k % 2 == 0) m_x[k] = (m_x[k] + step) % HV;
                else            m_x[k] = (m_x[k] - step + HV) % HV;
              end
            end
          end
        end
      end
      2: if (tick) begin
        if (m_freeze == 0) m_state = 3;
        else               m_freeze--;
      end
      default: begin
        m_x      = home_x;
        m_frames = 0;
        m_state  = enable ? 1 : 0;
      end
    endcase
  endtask

  // Compare process: outputs are sampled at the falling edge, then the model
  // advances across the next rising edge using the (stable) current inputs.
  initial begin
    bit cur_tick;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      cur_tick = rst_n && (m_n >= 1) && ((m_n % FRAME) == TICK_POS);
      check("frame_tick", frame_tick, cur_tick);
      check("state", state, m_state);
      check("collision", collision, m_coll);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("car%0d_x", k + 1), dut_x[k], m_x[k]);
        check($sformatf("car%0d_y", k + 1), dut_y[k], home_y[k]);
      end
      if (rst_n) begin
        if (cur_tick) tick_count++;
        model_step(cur_tick);
        m_n++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic wait_ticks(input int k);
    int target;
    int budget;
    target = tick_count + k;
    budget = (k + 2) * FRAME;
    while (tick_count < target && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (tick_count < target) check("wait_ticks_timeout", tick_count, target);
  endtask

  task automatic check_x(input string tag, input int x1, input int x2,
                         input int x3, input int x4);
    check({tag, "_x1"}, car_1x, x1);
    check({tag, "_x2"}, car_2x, x2);
    check({tag, "_x3"}, car_3x, x3);
    check({tag, "_x4"}, car_4x, x4);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_collision", collision, 0);
    check_x("rst", 0, 608, 160, 448);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired before the end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick_edges [$];
    int fx, fy, k;

    // Reset and tick timing.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_state", state, 0);
    check_x("reset", 0, 608, 160, 448);
    check("reset_y1", car_1y, 96);
    check("reset_y4", car_4y, 288);
    for (int i = 1; i <= 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (frame_tick) tick_edges.push_back(i);
    end
    check("tick_count_3frames", tick_edges.size(), 3);
    if (tick_edges.size() == 3) begin
      check("tick_first_edge", tick_edges[0], TICK_POS);
      check("tick_period_1", tick_edges[1] - tick_edges[0], FRAME);
      check("tick_period_2", tick_edges[2] - tick_edges[1], FRAME);
    end

    // Basic motion, level 0, one step every two ticks.
    enable = 1'b1;
    wait_ticks(1);
    check("entry_state", state, 1);
    check_x("entry", 0, 608, 160, 448);
    wait_ticks(2);
    check_x("move1", 1, 606, 163, 444);
    wait_ticks(2);
    check_x("move2", 2, 604, 166, 440);
    check("move2_y2", car_2y, 160);
    check("move2_y3", car_3y, 224);

    // Pause and resume.
    enable = 1'b0;
    @(posedge clk); #1;
    check("pause_state", state, 0);
    wait_ticks(5);
    check_x("pause_hold", 2, 604, 166, 440);
    enable = 1'b1;
    wait_ticks(1);
    check("resume_state", state, 1);
    wait_ticks(2);
    check_x("resume_move", 3, 602, 169, 436);

    // Wrap at level 3.
    level = 2'd3;
    do_reset();
    wait_ticks(1);
    wait_ticks(2 * 76);
    check("wrap_car2_zero", car_2x, 0);
    check("wrap_car1_76", car_1x, 304);
    wait_ticks(2);
    check("wrap_car2_632", car_2x, 632);
    wait_ticks(2 * 82);
    check("wrap_car1_636", car_1x, 636);
    wait_ticks(2);
    check("wrap_car1_zero", car_1x, 0);

    // Collision on the first PLAY tick: freeze, restart, play.
    level  = 2'd0;
    frog_x = 10'd10;
    frog_y = 10'd100;
    do_reset();
    wait_ticks(1);
    check("coll_entry_state", state, 1);
    wait_ticks(1);
    check("coll_state_hit", state, 2);
    check("coll_pulse", collision, 1);
    frog_x = 10'd320;
    frog_y = 10'd448;
    @(posedge clk); #1;
    check("coll_pulse_end", collision, 0);
    wait_ticks(59);
    check("coll_still_frozen", state, 2);
    wait_ticks(1);
    check("coll_restart", state, 3);
    @(posedge clk); #1;
    check("coll_replay", state, 1);
    check_x("coll_home", 0, 608, 160, 448);

    // Move a little, hit car 1 off its home spot, then reset mid-HIT.
    wait_ticks(10);
    check_x("pre_hit", 5, 598, 175, 428);
    frog_x = 10'd20;
    frog_y = 10'd100;
    wait_ticks(1);
    check("hit2_state", state, 2);
    check_x("hit2_frozen", 5, 598, 175, 428);
    frog_x = 10'd320;
    frog_y = 10'd448;
    wait_ticks(10);
    check_x("hit2_still_frozen", 5, 598, 175, 428);
    do_reset();

    // Randomized phase.
    for (int c = 0; c < 15000; c++) begin
      @(posedge clk); #1;
      if (enable ? ($urandom_range(399) == 0) : ($urandom_range(39) == 0))
        enable = ~enable;
      if ($urandom_range(99) == 0) level = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) begin
        if ($urandom_range(2) == 0) begin
          k  = int'($urandom_range(3));
          fx = m_x[k] + int'($urandom_range(80)) - 40;
          fy = home_y[k] + int'($urandom_range(80)) - 40;
        end else begin
          fx = int'($urandom_range(1023));
          fy = int'($urandom_range(1023));
        end
        if (fx < 0) fx = 0;
        if (fy < 0) fy = 0;
        if (fx > 1023) fx = 1023;
        if (fy > 1023) fy = 1023;
        frog_x = 10'(fx);
        frog_y = 10'(fy);
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
